// File: rtl/rsa_result_reader_pkg.sv
// rsa_pkg: shared state type and sizing helpers for the RSA result reader.
package rsa_pkg;
  typedef enum logic {IDLE, SEND} rsa_rd_state_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/rsa_chunk_counter.sv
// rsa_chunk_counter: slice index counter that saturates at NCHUNK-1 and flags the last slice.
module rsa_chunk_counter
  import rsa_pkg::*;
#(
  parameter int NCHUNK = 2,
  parameter int CW     = cnt_width(NCHUNK)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          ena,
  input  logic          clear,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          is_last
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign is_last = cnt_q == CW'(NCHUNK - 1);
  assign cnt     = cnt_q;
  always_comb
    cnt_d = !ena ? cnt_q : (clear | load) ? '0 : (inc & !is_last) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/rsa_result_reader.sv
// rsa_result_reader: captures a result word and streams it out LSB slice first over valid/ready.
module rsa_result_reader
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             abort,
  input  logic             capture,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  rsa_rd_state_t    state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             overrun_q, overrun_d;
  logic [CW-1:0]    cnt;
  logic             is_last, xfer, fin, load, inc;
  assign busy      = state_q == SEND;
  assign out_valid = busy & ena;
  assign out_data  = busy ? shadow_q[CHUNK-1:0] : '0;
  assign out_last  = busy & is_last;
  assign overrun   = overrun_q;
  assign xfer      = out_valid & out_ready;
  assign fin       = xfer & is_last;
  assign load      = !abort & capture & (!busy | fin);
  assign inc       = !abort & xfer & !is_last;
  rsa_chunk_counter #(.NCHUNK(NCHUNK), .CW(CW)) u_cnt (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(abort), .load(load), .inc(inc),
    .cnt(cnt), .is_last(is_last)
  );
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    if (ena) begin
      if (abort) begin
        state_d   = IDLE;
        shadow_d  = '0;
        overrun_d = 1'b0;
      end else if (load) begin
        state_d  = SEND;
        shadow_d = data_in;
      end else if (busy) begin
        state_d   = fin ? IDLE : SEND;
        shadow_d  = xfer ? shadow_q >> CHUNK : shadow_q;
        overrun_d = overrun_q | capture;
      end
    end
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
endmodule
